if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  - FIFO between I-cache (Icache) and decode; absorbs I-cache miss stalls (Stall_IF) and decode stalls (stallD).
//  - Stores {pc, instr} pairs; first-word fall-through to decode; flushed on branch/jump redirect.
//  - fq_ready back-pressures the PC/fetch stage; decode consumes via dec_valid/dec_ready.
// PARAMETERS
//  XLEN     32  instruction and PC width
//  DEPTH    4   entries; power of 2, >=2
//  PTR_W    2   log2(DEPTH); pointer width; count is PTR_W+1 bits
//  NOP_INST 32'h0000_0013  value driven on dec_instr when empty (addi x0,x0,0)
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     asynchronous, active-low reset
//  ic_valid      in   1     I-cache word valid this cycle (= ~Stall_IF)
//  ic_instr      in   XLEN  I-cache Data_out
//  ic_pc         in   XLEN  PC of ic_instr
//  fq_ready      out  1     queue can accept a push this cycle
//  flush         in   1     redirect (taken branch / jal); discard all entries
//  dec_valid     out  1     head entry valid
//  dec_ready     in   1     decode accepts head (= ~stallD)
//  dec_instr     out  XLEN  head instruction (NOP_INST when empty)
//  dec_pc        out  XLEN  head PC (0 when empty)
//  fq_count      out  PTR_W+1  entries held, 0..DEPTH
//  ovf_err       out  1     sticky: push attempted while full
//  dec_is_branch out  1     predecode: head opcode 1100011
//  dec_is_jump   out  1     predecode: head opcode 1101111 or 1100111
// BEHAVIOUR
//  - Reset (async, rst_n=0): wr_ptr=rd_ptr=0, fq_count=0, dec_valid=0, dec_instr=NOP_INST,
//    dec_pc=0, fq_ready=1, ovf_err=0, predecode outputs 0. Storage array not reset.
//  - push = ic_valid & fq_ready & ~flush; pop = dec_valid & dec_ready & ~flush.
//  - fq_ready = (fq_count != DEPTH); depends on registered state only, never on dec_ready
//    (no comb path decode->fetch). Full & pop in same cycle still deasserts fq_ready.
//  - Push: mem[wr_ptr] <= {ic_pc, ic_instr}; wr_ptr+1 mod DEPTH (natural wrap, PTR_W bits).
//  - Pop: rd_ptr+1 mod DEPTH.
//  - fq_count: +1 push only, -1 pop only, unchanged push&pop; never exceeds DEPTH or goes below 0.
//  - Latency: word pushed at edge N into empty queue -> dec_valid=1 with that word after edge N.
//  - dec_valid = (fq_count != 0); dec_instr/dec_pc = mem[rd_ptr] when valid, else NOP_INST/0.
//  - Empty & ic_valid: no bypass; word appears one cycle later.
//  - Flush (highest priority): at the edge, wr_ptr=rd_ptr=0, fq_count=0; same-cycle push and
//    pop both suppressed; ovf_err unchanged. Back-to-back flushes keep queue empty.
//  - ic_valid=1 while fq_ready=0 and no flush: word dropped, state unchanged, ovf_err<=1
//    (sticky until reset). Fetch must hold PC when fq_ready=0.
//  - Reset asserted mid-operation: all state cleared asynchronously; no entry survives.
// CONFIGURATION
//  - FQ_PREDECODE_EN defined: dec_is_branch/dec_is_jump decoded combinationally from
//    dec_instr[6:0], gated by dec_valid.
//  - FQ_PREDECODE_EN undefined: dec_is_branch=dec_is_jump=0 constantly; ports still present.
// TESTING
//  - Reset: rst_n=0 mid-traffic -> immediately fq_count=0, dec_valid=0, dec_instr=32'h13, fq_ready=1.
//  - Fill: dec_ready=0, push pc 0x00,0x04,0x08,0x0C -> fq_count=4, fq_ready=0; 5th ic_valid dropped, ovf_err=1.
//  - Drain order: after fill, dec_ready=1 -> dec_pc 0x00,0x04,0x08,0x0C on 4 consecutive cycles, then dec_valid=0.
//  - Wrap + simultaneous: steady ic_valid=1, dec_ready=1 for 10 words -> fq_count stays 1, PCs in order across pointer wrap.
//  - Flush: 3 entries held, flush=1 with ic_valid=1 -> next cycle fq_count=0, dec_valid=0, flushed-cycle word absent.
//  - Predecode (FQ_PREDECODE_EN): head 0x0000006F -> dec_is_jump=1; 0x00000063 -> dec_is_branch=1; undefined -> both 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: {pc, instr} FIFO between the I-cache and decode with first-word fall-through.
// Define FQ_PREDECODE_EN to drive dec_is_branch/dec_is_jump from the head opcode.
module if_fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter int               PTR_W    = 2,
    parameter logic [XLEN-1:0]  NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ic_valid,
    input  logic [XLEN-1:0]  ic_instr,
    input  logic [XLEN-1:0]  ic_pc,
    output logic             fq_ready,
    input  logic             flush,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [XLEN-1:0]  dec_instr,
    output logic [XLEN-1:0]  dec_pc,
    output logic [PTR_W:0]   fq_count,
    output logic             ovf_err,
    output logic             dec_is_branch,
    output logic             dec_is_jump
);

    localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] LP_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] LP_PINC = PTR_W'(1);

    logic [XLEN-1:0]  r_mem_pc    [DEPTH];
    logic [XLEN-1:0]  r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ovf;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Ready/valid come only from registered count: no decode->fetch path.
    assign w_full  = (r_count == LP_FULL);
    assign w_valid = (r_count != '0);
    assign w_push  = ic_valid & ~w_full & ~flush;
    assign w_pop   = w_valid & dec_ready & ~flush;
    assign w_drop  = ic_valid & w_full & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + LP_PINC;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PINC;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_ONE;
                2'b01:   r_count <= r_count - LP_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Storage is intentionally not reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= ic_pc;
            r_mem_instr[r_wr_ptr] <= ic_instr;
        end
    end

    assign fq_ready  = ~w_full;
    assign dec_valid = w_valid;
    assign fq_count  = r_count;
    assign ovf_err   = r_ovf;
    assign dec_instr = w_valid ? r_mem_instr[r_rd_ptr] : NOP_INST;
    assign dec_pc    = w_valid ? r_mem_pc[r_rd_ptr] : '0;

`ifdef FQ_PREDECODE_EN
    logic [6:0] w_op;
    assign w_op          = dec_instr[6:0];
    assign dec_is_branch = w_valid & (w_op == 7'b1100011);
    assign dec_is_jump   = w_valid & ((w_op == 7'b1101111) | (w_op == 7'b1100111));
`else
    assign dec_is_branch = 1'b0;
    assign dec_is_jump   = 1'b0;
`endif

endmodule
